arcade_key_decoder: RTL and testbench
=====================================

# arcade_key_decoder

Turns the hps_io PS/2 key event bus and the raw joystick coin bit into held player-button levels and a shaped, queued coin pulse. It sits between hps_io and the per-player direction filter / game core input bytes in the arcade emu top level. It replaces ad-hoc key decoding: every emu top instantiates it once on clk_sys.

## Interface
- COIN_ON, default 24'd2400000: coin output high time in clk_sys cycles (100 ms at 24 MHz); legal range ≥1.
- COIN_GAP, default 24'd2400000: minimum low time between coin pulses, in cycles; legal range ≥1.
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggles once per key event, [9] 1 = make / 0 = break, [8:0] scan code with bit 8 = E0 extended.
- joy_coin  in  1  raw joystick coin level (OR of all pads).
- clear  in  1  synchronous: release all keys, flush coin queue.
- p1  out  5  {fire, right, left, down, up}, held levels.
- p2  out  5  same layout, player 2.
- start1, start2  out  1  held levels.
- coin  out  1  shaped coin pulse.
- coin_busy  out  1  high when the FSM is not IDLE or pending≠0.

## Operation
- Event detect: tog_q holds the last sampled ps2_key[10]. An event fires in a cycle where ps2_key[10]≠tog_q and primed=1. primed is 0 after reset. The first clock after reset sets primed, loads tog_q and decodes nothing. This prevents a stale toggle from producing a spurious event.
- Key map:
  - Up, down, left, right: codes x75, x72, x6B, x74. Extended bit is ignored, so arrows and keypad both work. They drive p1 up/down/left/right.
  - p1 fire: 029 (space) or 014 (left ctrl). The two keys are tracked as separate held bits and ORed.
  - Player 2: R 02D up, F 02B down, D 023 left, G 034 right, A 01C fire.
  - start1: 005 (F1) or 016 (1). start2: 006 (F2) or 01E (2). Each key is tracked separately and ORed.
  - Coin keys: 004 (F3), 02E (5), 036 (6).
  - All other codes are ignored.
- Held state: a make sets the key bit and a break clears it. Typematic repeats are makes on an already-set bit and have no effect.
- Coin request: a coin key bit going 0→1, or a joy_coin rising edge (joy_coin registered once). Each request increments pending (2 bits, saturates at 3).
- Coin FSM:
  - IDLE: if pending≠0, go to ON, decrement pending, load cnt=COIN_ON-1.
  - ON: coin=1. At cnt=0, go to GAP and load cnt=COIN_GAP-1; otherwise decrement cnt.
  - GAP: coin=0. At cnt=0, go to IDLE; otherwise decrement cnt.
- Simultaneous events:
  - A request in the same cycle as an IDLE→ON decrement leaves pending unchanged.
  - A coin key request and a joy_coin edge in the same cycle add 2, saturating.
- clear:
  - Next cycle: all held bits=0, pending=0, FSM=IDLE, coin=0.
  - A running pulse is truncated.
  - clear has priority over an event in the same cycle.

## Timing
- Reset values: p1=p2=0, start1=start2=0, coin=0, coin_busy=0, FSM=IDLE, pending=0, primed=0, tog_q=0, cnt=0.
- Held outputs are registered. Toggle change sampled at edge n gives the new level after edge n (one-cycle latency).
- Coin path: event sampled at edge n, pending updated at n, IDLE→ON at n+1, so coin is high after edge n+1. Coin stays high exactly COIN_ON cycles, then low for at least COIN_GAP cycles.
- Back-to-back queued coins: rising edges are COIN_ON+COIN_GAP+1 cycles apart (the IDLE cycle is included).
- Reset asserted mid-pulse: coin drops asynchronously. After release, primed rule applies.
- cnt is 24 bits. COIN_ON/COIN_GAP values ≥2^24 are illegal.

## Test plan
- Reset release with ps2_key[10]=1 held → no outputs change, primed=1 after the first edge.
- Make 0x75 then make 0x16 (two toggles) → p1=5'b00001, start1=1. Break 0x75 → p1=0. Make 0x175 → p1[0]=1.
- Make 029, make 014, break 029 → p1[4] stays 1. Break 014 → p1[4]=0.
- COIN_ON=4, COIN_GAP=3; single F3 make at edge n → coin high for edges n+1…n+4, low n+5…n+7, coin_busy low from n+8.
- Four coin requests within 2 cycles (F3 make, joy_coin edge, 5 make, 6 make) → pending saturates at 3, giving exactly 3 pulses spaced 8 cycles. Repeated F3 makes without a break add none.
- clear asserted during ON with pending=2 → coin=0 and coin_busy=0 next cycle, all held bits 0. A make arriving in the same cycle as clear is dropped.

Source files
------------

// File: rtl/arcade_key_decoder_if.sv
// Key/coin bus between hps_io-side stimulus and arcade_key_decoder.
// slave = decoder side, master = whoever drives the keyboard/joystick events.
interface arcade_key_decoder_if;
  logic [10:0] ps2_key;
  logic        joy_coin;
  logic        clear;
  logic [4:0]  p1;
  logic [4:0]  p2;
  logic        start1;
  logic        start2;
  logic        coin;
  logic        coin_busy;

  modport slave (
    input  ps2_key, joy_coin, clear,
    output p1, p2, start1, start2, coin, coin_busy
  );

  modport master (
    output ps2_key, joy_coin, clear,
    input  p1, p2, start1, start2, coin, coin_busy
  );
endinterface

// File: rtl/arcade_key_decoder.sv
// PS/2 key events -> held player buttons, plus a queued, shaped coin pulse
// driven by coin keys and the joystick coin bit.
module arcade_key_decoder #(
  parameter logic [23:0] COIN_ON  = 24'd2400000,
  parameter logic [23:0] COIN_GAP = 24'd2400000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  arcade_key_decoder_if.slave   bus
);

  localparam int NKEYS = 18;
  // Index 0 is the LSB entry: p1 dirs, p1 fires, p2 keys, starts, coin keys.
  localparam logic [NKEYS*9-1:0] KEY_CODES = {
    9'h036, 9'h02E, 9'h004,
    9'h01E, 9'h006, 9'h016, 9'h005,
    9'h01C, 9'h034, 9'h023, 9'h02B, 9'h02D,
    9'h014, 9'h029,
    9'h074, 9'h06B, 9'h072, 9'h075
  };
  localparam logic [NKEYS-1:0] IGNORE_EXT = 18'h0000F;
  localparam logic [NKEYS-1:0] COIN_KEYS  = 18'h38000;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  logic [NKEYS-1:0] key_hit;
  logic [NKEYS-1:0] held_q, held_d;
  logic             primed_q, tog_q, joy_q;
  logic [4:0]       p1_q, p2_q;
  logic             start1_q, start2_q;
  logic             ps2_event, coin_key_req, joy_rise, launch;
  logic [1:0]       req_cnt;
  logic [2:0]       pending_sum;
  logic [1:0]       pending_q, pending_d;
  state_t           state_q;
  logic [23:0]      cnt_q;
  logic             coin_q, busy_q;

  // Arrow codes match with or without the E0 prefix so keypad arrows work too.
  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_match
      localparam logic [8:0] CODE = KEY_CODES[gi*9 +: 9];
      if (IGNORE_EXT[gi]) begin : g_any
        assign key_hit[gi] = (bus.ps2_key[7:0] == CODE[7:0]);
      end else begin : g_exact
        assign key_hit[gi] = (bus.ps2_key[8:0] == CODE);
      end
    end
  endgenerate

  assign ps2_event    = primed_q && (bus.ps2_key[10] != tog_q);
  assign coin_key_req = ps2_event && bus.ps2_key[9] && |(key_hit & COIN_KEYS & ~held_q);
  assign joy_rise     = bus.joy_coin && !joy_q;

  always_comb begin
    held_d = held_q;
    if (bus.clear) begin
      held_d = '0;
    end else if (ps2_event) begin
      held_d = bus.ps2_key[9] ? (held_q | key_hit) : (held_q & ~key_hit);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      primed_q <= 1'b0;
      tog_q    <= 1'b0;
      joy_q    <= 1'b0;
      held_q   <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      // tog_q tracks even while clear is high, so a dropped event never replays.
      primed_q <= 1'b1;
      tog_q    <= bus.ps2_key[10];
      joy_q    <= bus.joy_coin;
      held_q   <= held_d;
      p1_q     <= {held_d[5] | held_d[4], held_d[3:0]};
      p2_q     <= held_d[10:6];
      start1_q <= held_d[12] | held_d[11];
      start2_q <= held_d[14] | held_d[13];
    end
  end

  assign req_cnt     = {1'b0, coin_key_req} + {1'b0, joy_rise};
  assign launch      = (state_q == S_IDLE) && (pending_q != 2'd0);
  assign pending_sum = {1'b0, pending_q} + {1'b0, req_cnt} - {2'b00, launch};
  assign pending_d   = bus.clear ? 2'd0 :
                       (pending_sum > 3'd3) ? 2'd3 : pending_sum[1:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      coin_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (bus.clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      coin_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q <= S_ON;
            cnt_q   <= COIN_ON - 24'd1;
            coin_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= (pending_d != 2'd0);
          end
        end
        S_ON: begin
          busy_q <= 1'b1;
          if (cnt_q == 24'd0) begin
            state_q <= S_GAP;
            cnt_q   <= COIN_GAP - 24'd1;
            coin_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 24'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == 24'd0) begin
            state_q <= S_IDLE;
            busy_q  <= (pending_d != 2'd0);
          end else begin
            cnt_q   <= cnt_q - 24'd1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          coin_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p1        = p1_q;
  assign bus.p2        = p2_q;
  assign bus.start1    = start1_q;
  assign bus.start2    = start2_q;
  assign bus.coin      = coin_q;
  assign bus.coin_busy = busy_q;

endmodule

// File: tb/tb_arcade_key_decoder.sv
// Bench for arcade_key_decoder: key-map vector table, coin timing sequences,
// then random traffic against a timestamp-based reference model.
module tb_arcade_key_decoder;

  localparam logic [23:0] C_ON  = 24'd4;
  localparam logic [23:0] C_GAP = 24'd3;
  localparam int ON  = 4;
  localparam int GAP = 3;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  arcade_key_decoder_if bus();

  arcade_key_decoder #(.COIN_ON(C_ON), .COIN_GAP(C_GAP)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model: set of held scan codes plus the edge index at which
  // the current coin pulse started.
  bit  kd [512];
  bit  m_primed, m_prev_tog, m_joy_prev;
  int  m_pending;
  int  m_cyc = 0;
  int  m_start;
  int  rises[$];
  logic coin_prev = 1'b0;

  typedef struct {
    bit         make;
    logic [8:0] code;
    logic [4:0] p1;
    logic [4:0] p2;
    logic       s1;
    logic       s2;
  } vec_t;
  vec_t tbl[$];

  logic [8:0] rnd_codes [26] = '{
    9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h174,
    9'h029, 9'h014, 9'h114, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C,
    9'h005, 9'h016, 9'h006, 9'h01E, 9'h004, 9'h02E, 9'h036, 9'h104,
    9'h00A, 9'h15A
  };

  function automatic logic [8:0] norm(input logic [8:0] c);
    if (c[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) return {1'b0, c[7:0]};
    return c;
  endfunction

  function automatic bit is_coin(input logic [8:0] c);
    return (c == 9'h004) || (c == 9'h02E) || (c == 9'h036);
  endfunction

  task automatic model_reset();
    foreach (kd[i]) kd[i] = 1'b0;
    m_primed   = 1'b0;
    m_prev_tog = 1'b0;
    m_joy_prev = 1'b0;
    m_pending  = 0;
    m_start    = -1000;
  endtask

  task automatic model_step();
    bit         ev;
    int         req;
    bit         dec;
    logic [8:0] c;
    m_cyc++;
    ev  = 1'b0;
    req = 0;
    dec = 1'b0;
    if (!m_primed) begin
      m_primed   = 1'b1;
      m_prev_tog = bus.ps2_key[10];
    end else begin
      ev         = (bus.ps2_key[10] != m_prev_tog);
      m_prev_tog = bus.ps2_key[10];
    end
    if (bus.joy_coin && !m_joy_prev) req++;
    m_joy_prev = bus.joy_coin;
    if (bus.clear) begin
      foreach (kd[i]) kd[i] = 1'b0;
      m_pending = 0;
      m_start   = -1000;
    end else begin
      if (ev) begin
        c = norm(bus.ps2_key[8:0]);
        if (bus.ps2_key[9]) begin
          if (is_coin(c) && !kd[c]) req++;
          kd[c] = 1'b1;
        end else begin
          kd[c] = 1'b0;
        end
      end
      // The FSM was idle after the previous edge once the whole ON+GAP window elapsed.
      if ((m_cyc - 1) >= m_start + ON + GAP && m_pending > 0) begin
        m_start = m_cyc;
        dec     = 1'b1;
      end
      m_pending = m_pending + req - int'(dec);
      if (m_pending > 3) m_pending = 3;
    end
  endtask

  function automatic logic [13:0] model_out();
    logic [4:0] p1, p2;
    logic       s1, s2, cn, bz;
    p1 = {kd[9'h029] | kd[9'h014], kd[9'h074], kd[9'h06B], kd[9'h072], kd[9'h075]};
    p2 = {kd[9'h01C], kd[9'h034], kd[9'h023], kd[9'h02B], kd[9'h02D]};
    s1 = kd[9'h005] | kd[9'h016];
    s2 = kd[9'h006] | kd[9'h01E];
    cn = (m_cyc >= m_start) && ((m_cyc - m_start) < ON);
    bz = (m_cyc < m_start + ON + GAP) || (m_pending != 0);
    return {p1, p2, s1, s2, cn, bz};
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.p1, bus.p2, bus.start1, bus.start2, bus.coin, bus.coin_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    if (reset_n) model_step();
    #1;
    check("outputs", 32'(dut_out()), 32'(model_out()));
    if (bus.coin && !coin_prev) rises.push_back(m_cyc);
    coin_prev = bus.coin;
  endtask

  task automatic send_key(input bit make, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], make, code};
    $display("key %s %03h  clear=%0b joy=%0b", make ? "make " : "break", code, bus.clear, bus.joy_coin);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ps2_key  = {1'b1, 1'b1, 9'h075};
    bus.joy_coin = 1'b0;
    bus.clear    = 1'b0;
    model_reset();

    // Reset with a stale toggle held high: nothing may decode.
    #2;
    check("reset_state", 32'(dut_out()), 32'd0);
    #10 reset_n = 1'b1;
    step();
    check("prime_edge", 32'(dut_out()), 32'd0);
    step();
    check("no_stale_event", 32'(dut_out()), 32'd0);

    tbl.push_back('{1'b1, 9'h075, 5'b00001, 5'b00000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 9'h016, 5'b00001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h075, 5'b00000, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h175, 5'b00001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h029, 5'b10001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h014, 5'b10001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h029, 5'b10001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h014, 5'b00001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h114, 5'b00001, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h075, 5'b00000, 5'b00000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h02D, 5'b00000, 5'b00001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h02B, 5'b00000, 5'b00011, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h023, 5'b00000, 5'b00111, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h034, 5'b00000, 5'b01111, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h01C, 5'b00000, 5'b11111, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h00A, 5'b00000, 5'b11111, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 9'h005, 5'b00000, 5'b11111, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h016, 5'b00000, 5'b11111, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 9'h005, 5'b00000, 5'b11111, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 9'h006, 5'b00000, 5'b11111, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 9'h01E, 5'b00000, 5'b11111, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 9'h006, 5'b00000, 5'b11111, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 9'h01E, 5'b00000, 5'b11111, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 9'h16B, 5'b00100, 5'b11111, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 9'h074, 5'b01100, 5'b11111, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 9'h172, 5'b01110, 5'b11111, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h02D, 5'b01110, 5'b11110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h01C, 5'b01110, 5'b01110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h06B, 5'b01010, 5'b01110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h174, 5'b00010, 5'b01110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h072, 5'b00000, 5'b01110, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h02B, 5'b00000, 5'b01100, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h023, 5'b00000, 5'b01000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 9'h034, 5'b00000, 5'b00000, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      send_key(tbl[i].make, tbl[i].code);
      check($sformatf("vec%0d", i),
            32'({bus.p1, bus.p2, bus.start1, bus.start2}),
            32'({tbl[i].p1, tbl[i].p2, tbl[i].s1, tbl[i].s2}));
    end

    // Single coin: high for edges n+1..n+4, idle from n+8; a typematic repeat adds nothing.
    send_key(1'b1, 9'h004);
    check("coinA_n", 32'({bus.coin, bus.coin_busy}), 32'b01);
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) send_key(1'b1, 9'h004);
      else        step();
      check($sformatf("coinA_k%0d", k), 32'({bus.coin, bus.coin_busy}),
            32'({(k >= 1 && k <= 4) ? 1'b1 : 1'b0, (k < 8) ? 1'b1 : 1'b0}));
    end
    send_key(1'b0, 9'h004);

    // Queue saturation: one running pulse plus four requests -> three more pulses.
    rises.delete();
    send_key(1'b1, 9'h036);
    step();
    bus.joy_coin = 1'b1;
    send_key(1'b1, 9'h004);
    send_key(1'b1, 9'h02E);
    send_key(1'b0, 9'h036);
    send_key(1'b1, 9'h036);
    repeat (40) step();
    check("coinB_pulses", 32'(rises.size()), 32'd4);
    for (int i = 1; i < rises.size(); i++)
      check($sformatf("coinB_gap%0d", i), 32'(rises[i] - rises[i-1]), 32'(ON + GAP + 1));
    check("coinB_idle", 32'(bus.coin_busy), 32'd0);
    bus.joy_coin = 1'b0;
    send_key(1'b0, 9'h004);
    send_key(1'b0, 9'h02E);
    send_key(1'b0, 9'h036);

    // clear during ON with pending=2, plus a make in the same cycle.
    bus.joy_coin = 1'b1;
    send_key(1'b1, 9'h004);
    step();
    check("coinC_on", 32'(bus.coin), 32'd1);
    send_key(1'b1, 9'h02E);
    bus.clear = 1'b1;
    send_key(1'b1, 9'h029);
    check("clear_all", 32'(dut_out()), 32'd0);
    bus.clear = 1'b0;
    step();
    check("clear_drop", 32'({bus.p1, bus.coin_busy}), 32'd0);
    step();
    check("clear_quiet", 32'({bus.coin, bus.coin_busy}), 32'd0);
    bus.joy_coin = 1'b0;
    step();

    // Asynchronous reset in the middle of a pulse.
    send_key(1'b1, 9'h004);
    step();
    check("coinD_on", 32'(bus.coin), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'd0);
    model_reset();
    coin_prev = 1'b0;
    step();
    bus.ps2_key = {~bus.ps2_key[10], 1'b1, 9'h075};
    step();
    reset_n = 1'b1;
    step();
    check("reprime", 32'(dut_out()), 32'd0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) bus.joy_coin = ~bus.joy_coin;
      bus.clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 35)
        send_key(1'($urandom_range(0, 1)), rnd_codes[$urandom_range(0, 25)]);
      else
        step();
    end
    bus.clear = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
